// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchroniser, mid-bit sampling, 8 data bits LSB first, stop check.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (sense set by PARITY_ODD).
module uart_rx #(
  parameter int CLK_PER_BIT = 260,
  parameter int CNT_W       = 9,
  parameter bit PARITY_ODD  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_busy,
  output logic       rx_end,
  output logic [7:0] rx_data,
  output logic       rx_err
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state, state_nx;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             div_clr, sample, end_nx, err_nx, cnt_run, div_last;
  logic             par_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign cnt_run  = (state != IDLE) && (state != BREAK);
  assign div_last = (div_cnt == LAST);
  assign rx_busy  = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_smp;

  always_ff @(posedge clk) begin
    if (reset)              par_err <= 1'b0;
    else if (state == START) par_err <= 1'b0;
    else if (par_smp)       par_err <= (rx_s != (PARITY_ODD ? ~^shift : ^shift));
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
  assign par_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    div_clr  = 1'b0;
    sample   = 1'b0;
    end_nx   = 1'b0;
    err_nx   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_smp  = 1'b0;
`endif
    case (state)
      IDLE: if (!rx_s) begin
        state_nx = START;
        div_clr  = 1'b1;
      end
      START: if (div_cnt == HALF) begin
        div_clr  = 1'b1;
        state_nx = rx_s ? IDLE : DATA;  // high at mid-start is a glitch
      end
      DATA: if (div_last) begin
        div_clr = 1'b1;
        sample  = 1'b1;
        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (div_last) begin
        div_clr  = 1'b1;
        par_smp  = 1'b1;
        state_nx = STOP;
      end
`endif
      STOP: if (div_last) begin
        div_clr = 1'b1;
        if (rx_s && !par_err) begin
          end_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          err_nx   = 1'b1;
          state_nx = rx_s ? IDLE : BREAK;  // a low stop must go high before rearming
        end
      end
      BREAK: if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      rx_data <= 8'h00;
      rx_end  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= (div_clr || !cnt_run) ? '0 : div_cnt + 1'b1;
      if (state == START) bit_cnt <= 3'd0;
      else if (sample)    bit_cnt <= bit_cnt + 3'd1;
      if (sample) shift <= {rx_s, shift[7:1]};
      if (end_nx) rx_data <= shift;
      rx_end <= end_nx;
      rx_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at CLK_PER_BIT=16; frames are modelled as whole
// bit sequences, and the expected strobe (kind, cycle, byte) is queued when a frame is sent.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int HALF = CPB/2 - 1;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB  = PAR_EN ? 11 : 10;
  // start bit driven in cycle c0 -> 2 sync + 1 detect + mid-start + remaining bit periods -> strobe cycle
  localparam int LAT = 3 + HALF + 1 + (NB - 1) * CPB;

  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic       rx_busy, rx_end, rx_err;
  logic [7:0] rx_data;

  uart_rx #(.CLK_PER_BIT(CPB), .CNT_W(5), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data), .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit err; logic [7:0] d; longint at; } exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [7:0] mdl_data = 8'h00;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(bit b);
    rx = b;
    tick(CPB);
  endtask

  // Reference: a frame is good iff stop is 1 and (if enabled) parity is even over data+parity.
  task automatic send(logic [7:0] d, bit stop_b, bit par_flip);
    exp_t e;
    bit   ok;
    longint c0;
    ok = stop_b && !(PAR_EN && par_flip);
    if (ok) mdl_data = d;
    c0 = cyc;
    e.err = !ok; e.d = mdl_data; e.at = c0 + LAT;
    q.push_back(e);
    rx = 1'b0;
    tick(2);
    chk("busy_before_detect", rx_busy, 1'b0);
    tick(1);
    chk("busy_rise", rx_busy, 1'b1);
    tick(CPB - 3);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(^d ^ par_flip);
    drive_bit(stop_b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin tick(1); n++; end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d strobes still pending after timeout", q.size());
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rx_end || rx_err)) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_strobe: end=%0b err=%0b data=%0h cycle %0d", rx_end, rx_err, rx_data, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("strobe_kind_err", rx_err, mon_e.err);
        chk("strobe_excl", rx_end & rx_err, 1'b0);
        chk("strobe_cycle", cyc, mon_e.at);
        chk("rx_data", rx_data, mon_e.d);
        if (rx_end) chk("busy_in_end_cycle", rx_busy, 1'b0);
      end
    end
  end

  initial begin
    tick(4);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_end", rx_end, 1'b0);
    chk("rst_err", rx_err, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    reset = 1'b0;
    tick(3);

    send(8'hA5, 1'b1, 1'b0);
    rx = 1'b1; tick(CPB);
    drain();
    chk("a5_hold", rx_data, 8'hA5);

    // glitch: 4 low clocks; busy cycles c0+3..c0+10
    rx = 1'b0; tick(4);
    rx = 1'b1; tick(3);
    chk("glitch_busy", rx_busy, 1'b1);
    tick(5);
    chk("glitch_idle", rx_busy, 1'b0);
    tick(CPB);

    // framing error followed by a held-low break
    send(8'h3C, 1'b0, 1'b0);
    tick(3 * CPB);
    chk("break_busy", rx_busy, 1'b1);
    rx = 1'b1; tick(3);
    chk("break_release", rx_busy, 1'b0);
    tick(CPB);
    drain();
    chk("ferr_data_kept", rx_data, 8'hA5);

    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    rx = 1'b1; tick(CPB);
    drain();

    for (int k = 0; k < 20; k++) begin
      logic [7:0] d;
      bit bad;
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send(d, !bad, 1'b0);
      if (bad) begin tick(2 * CPB); rx = 1'b1; tick(CPB); end
      else begin rx = 1'b1; tick(CPB * $urandom_range(0, 2)); end
    end
    rx = 1'b1; tick(CPB);
    drain();

    // reset in the middle of data bit 4 of 8'h5A
    rx = 1'b0; tick(CPB);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    rx = 1'b0; tick(CPB/2);   // bit 4 of 8'h5A is 1; hold low to prove nothing is captured
    reset = 1'b1; rx = 1'b1;
    tick(2);
    chk("midrst_busy", rx_busy, 1'b0);
    chk("midrst_end", rx_end, 1'b0);
    chk("midrst_err", rx_err, 1'b0);
    chk("midrst_data", rx_data, 8'h00);
    mdl_data = 8'h00;
    reset = 1'b0;
    tick(CPB);
    send(8'h81, 1'b1, 1'b0);
    rx = 1'b1; tick(CPB);
    drain();

    if (PAR_EN) begin
      send(8'h07, 1'b1, 1'b0);
      rx = 1'b1; tick(CPB);
      send(8'h07, 1'b1, 1'b1);
      rx = 1'b1; tick(CPB);
      send(8'h3B, 1'b1, 1'b1);
      rx = 1'b1; tick(CPB);
      drain();
    end

    tick(CPB);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
